// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
// Requests use a valid/ready handshake; responses return in order, one per accepted request.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order fetches, buffers returned
// words and presents one instruction per cycle in a registered IF/ID slot with redirect support.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_unit_if.master          imem,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  id_stall,
  output logic                  id_valid,
  output logic [31:0]           id_instruction,
  output logic [6:0]            id_opcode,
  output logic [ADDR_WIDTH-1:0] id_pc
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam logic [PW-1:0]   LastIdx = PW'(DEPTH - 1);
  localparam logic [CW:0]     DepthW  = (CW + 1)'(DEPTH);
  localparam logic [31:0]     Nop     = 32'h0000_0013;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]         fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [PW-1:0]         tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]           fifo_word_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] tag_pc_q    [DEPTH];
  logic                  id_valid_q, id_valid_d;
  logic [31:0]           id_instr_q, id_instr_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;

  logic credit_ok, req_valid, req_fire, rsp_valid, rsp_keep;
  logic slot_free, fifo_empty, pop, bypass, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastIdx) ? '0 : p + PW'(1);
  endfunction

  // Outstanding requests plus buffered words never exceed DEPTH, so the FIFO cannot overflow.
  assign credit_ok  = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < DepthW;
  assign req_valid  = rst_n && !redirect_valid && credit_ok;
  assign req_fire   = req_valid && imem.imem_req_ready;
  assign rsp_valid  = imem.imem_rsp_valid;
  assign rsp_keep   = rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign slot_free  = !id_valid_q || !id_stall;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = !redirect_valid && slot_free && !fifo_empty;
  assign bypass     = rsp_keep && slot_free && fifo_empty;
  assign push       = rsp_keep && !bypass;

  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_valid);
    drop_cnt_d = drop_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    tag_wr_d   = req_fire  ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d   = rsp_valid ? ptr_inc(tag_rd_q) : tag_rd_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;

    if (redirect_valid) begin
      // Everything still in flight belongs to the wrong path, including a same-cycle response.
      pc_d       = redirect_pc;
      drop_cnt_d = out_cnt_q - CW'(rsp_valid);
      fifo_cnt_d = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      id_valid_d = 1'b0;
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_WIDTH'(4);
      if (rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
      if (push) fifo_wr_d = ptr_inc(fifo_wr_q);
      if (pop)  fifo_rd_d = ptr_inc(fifo_rd_q);
      if (slot_free) begin
        if (!fifo_empty) begin
          id_valid_d = 1'b1;
          id_instr_d = fifo_word_q[fifo_rd_q];
          id_pc_d    = fifo_pc_q[fifo_rd_q];
        end else if (bypass) begin
          id_valid_d = 1'b1;
          id_instr_d = imem.imem_rsp_data;
          id_pc_d    = tag_pc_q[tag_rd_q];
        end else begin
          id_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fifo_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= Nop;
      id_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Storage arrays carry no reset; their contents are qualified by the counters and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word_q[fifo_wr_q] <= imem.imem_rsp_data;
      fifo_pc_q[fifo_wr_q]   <= tag_pc_q[tag_rd_q];
    end
    if (req_fire) tag_pc_q[tag_wr_q] <= pc_q;
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc_q;
  assign id_valid            = id_valid_q;
  assign id_instruction      = id_instr_q;
  assign id_opcode           = id_instr_q[6:0];
  assign id_pc               = id_pc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined RISC-V core, directly upstream of decode and the immediate generator. It owns the PC and issues in-order requests to instruction memory over a valid/ready interface. It buffers returned words in a small FIFO and presents one instruction per cycle in a registered IF/ID slot (`id_instruction`, `id_opcode`, `id_pc`). It also handles decode stalls and branch redirects, discarding wrong-path responses.

## Interface
- `ADDR_WIDTH`, 32, PC / instruction-memory address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, maximum in-flight requests plus buffered words (FIFO depth, ≥2)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_req_addr`  out  ADDR_WIDTH  fetch address (= PC)
- `imem_rsp_valid`  in  1  response word valid; one per accepted request, in order, ≥1 cycle after acceptance
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  branch taken / PC override
- `redirect_pc`  in  ADDR_WIDTH  new fetch address
- `id_stall`  in  1  decode cannot accept; hold IF/ID slot
- `id_valid`  out  1  IF/ID slot holds a valid instruction
- `id_instruction`  out  32  instruction to decode
- `id_opcode`  out  7  `id_instruction[6:0]`, registered alongside it
- `id_pc`  out  ADDR_WIDTH  address of `id_instruction`

## Operation
- State:
  - `pc`
  - `out_cnt` (accepted requests awaiting response, 0..DEPTH)
  - `drop_cnt` (responses to discard, ≤ `out_cnt`)
  - FIFO of {word, pc} entries with `fifo_cnt`
  - a pc-tag FIFO matching outstanding requests
  - IF/ID slot
- Credit rule: `imem_req_valid` = `rst_n && !redirect_valid && (out_cnt + fifo_cnt < DEPTH)`. The FIFO can never overflow.
- Request accepted (valid && ready): `pc <= pc + 4`, `out_cnt++`. Address arithmetic is modulo 2^ADDR_WIDTH (wraps from all-ones minus 3 to 0).
- Response received:
  - `out_cnt--` always.
  - If `drop_cnt > 0`: `drop_cnt--` and the word is discarded.
  - Otherwise the word takes the path below.
- Response path:
  - If FIFO is empty and the slot can load (`!id_valid || !id_stall`), the word goes directly into the IF/ID slot.
  - Otherwise it is pushed into the FIFO.
- Slot load when `!id_valid || !id_stall`, priority: FIFO head, then bypassed response; `id_valid` is 0 if neither is present.
- `id_stall` with `id_valid`=1: slot holds all fields unchanged.
- Redirect (highest priority):
  - `pc <= redirect_pc`; FIFO cleared; `id_valid <= 0`.
  - `drop_cnt <= out_cnt`, minus 1 if a response arrives the same cycle. That response is discarded.
  - No request is issued in the redirect cycle, even if `imem_req_ready`=1.

## Timing
- Reset (async assert, sync release):
  - `pc`=RESET_PC; counters 0; FIFO empty
  - `id_valid`=0, `id_instruction`=32'h0000_0013 (NOP), `id_opcode`=7'h13, `id_pc`=0
  - `imem_req_valid`=0 while `rst_n`=0
- First request: `imem_req_valid`=1 in the first cycle after `rst_n` rises, with `imem_req_addr`=RESET_PC.
- Latency:
  - Response in cycle N → `id_valid`=1 in cycle N+1 when the slot is free.
  - Request-accept to `id_valid` = memory latency + 1.
- `imem_req_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0. Only a redirect may withdraw a pending request.
- Throughput: 1 instruction/cycle with 1-cycle memory and DEPTH≥2.
- Simultaneous events:
  - redirect+stall → redirect wins
  - redirect+response → response dropped
  - push+pop on the FIFO in the same cycle → `fifo_cnt` unchanged
- Reset mid-operation: all in-flight state lost. The memory model must also be reset; no stale response may arrive after `rst_n` rises.

## Test plan
- Reset release, ready=1, 1-cycle memory, no stall → requests to 0,4,8,…; `id_valid`=1 from cycle 2 after reset release; `id_pc` 0,4,8 on consecutive cycles; `id_opcode` matches `id_instruction[6:0]`.
- `id_stall` high for 4 cycles mid-stream (DEPTH=2) → slot frozen, `imem_req_valid` drops after 2 words are buffered; on release, `id_pc` resumes with no gap, duplicate or loss.
- `imem_req_ready`=0 for 5 cycles with addr 0x10 pending → `imem_req_addr` stays 0x10; fetch resumes at 0x10 afterwards.
- Redirect to 0x200 with 2 requests outstanding (3-cycle memory) → both old responses discarded, next `id_valid` shows `id_pc`=0x200.
- Redirect coincident with `imem_rsp_valid` and `id_stall` → `id_valid`=0 next cycle; that response is never presented; first request issued the next cycle to `redirect_pc`.
- Assert `rst_n` mid-stream with an instruction in the slot → `id_valid` drops immediately (async); after release, fetch restarts at RESET_PC.
